// File: rtl/au_pkg.sv
// Shared definitions for the AU family: opcode encodings and the default
// operand width.
package au_pkg;

  localparam int AU_W   = 16;
  localparam int AU_MSB = AU_W - 1;

  localparam logic [1:0] AU_SUB  = 2'b00;
  localparam logic [1:0] AU_ADD  = 2'b01;
  localparam logic [1:0] AU_MAX  = 2'b10;
  localparam logic [1:0] AU_MAX2 = 2'b11;

endpackage

// File: rtl/au2_core.sv
// Combinational AU kernel: wrapping signed sub/add or signed max with an
// overflow flag. Shared with the unregistered AU variants.
module au2_core
  import au_pkg::*;
#(
  parameter int msb = AU_MSB
) (
  input  logic signed [msb:0] a,
  input  logic signed [msb:0] b,
  input  logic        [1:0]   ctrl,
  output logic signed [msb:0] res,
  output logic                ovf
);

  logic [msb+1:0] diff_w;
  logic [msb+1:0] sum_w;

  // Overflow is flagged when the sign-extended W+1 bit result has its top two
  // bits disagreeing, i.e. the truncated result no longer fits in W bits.
  function automatic logic wrap_ovf(input logic [msb+1:0] wide);
    return wide[msb+1] ^ wide[msb];
  endfunction

  function automatic logic signed [msb:0] smax(input logic signed [msb:0] x,
                                               input logic signed [msb:0] y);
    return (x >= y) ? x : y;
  endfunction

  assign diff_w = {a[msb], a} - {b[msb], b};
  assign sum_w  = {a[msb], a} + {b[msb], b};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (ctrl)
      AU_SUB: begin
        res = $signed(diff_w[msb:0]);
        ovf = wrap_ovf(diff_w);
      end
      AU_ADD: begin
        res = $signed(sum_w[msb:0]);
        ovf = wrap_ovf(sum_w);
      end
      AU_MAX, AU_MAX2: begin
        res = smax(a, b);
        ovf = 1'b0;
      end
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/au2.sv
// Registered 2-input signed arithmetic unit for the SRA datapath: one cycle of
// latency, one operation per clock, no backpressure.
module au2
  import au_pkg::*;
#(
  parameter int msb = AU_MSB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [msb:0] In1,
  input  logic signed [msb:0] In2,
  input  logic        [1:0]   ctrl,
  input  logic                in_valid,
  output logic signed [msb:0] Out,
  output logic                out_valid,
  output logic                ovf
);

  logic signed [msb:0] res_p0;
  logic                ovf_p0;
  logic signed [msb:0] res_p1;
  logic                ovf_p1;
  logic                vld_p1;

  au2_core #(.msb(msb)) u_core (
    .a    (In1),
    .b    (In2),
    .ctrl (ctrl),
    .res  (res_p0),
    .ovf  (ovf_p0)
  );

  // p0 -> p1: result and flag hold across idle cycles; reset clears everything
  // so an in-flight result is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1 <= '0;
      ovf_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1 <= res_p0;
        ovf_p1 <= ovf_p0;
      end
    end
  end

  assign Out       = res_p1;
  assign ovf       = ovf_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_au2.sv
// Directed bench for au2: reset, the four opcodes, overflow corners, max
// corners, valid gating and mid-stream reset.
module tb_au2;

  logic               clk;
  logic               rst;
  logic signed [15:0] In1;
  logic signed [15:0] In2;
  logic        [1:0]  ctrl;
  logic               in_valid;
  logic signed [15:0] Out;
  logic               out_valid;
  logic               ovf;

  int checks;
  int errors;

  au2 #(.msb(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .In1       (In1),
    .In2       (In2),
    .ctrl      (ctrl),
    .in_valid  (in_valid),
    .Out       (Out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic signed [15:0] a,
                      input logic signed [15:0] b, input logic [1:0] c);
    rst      = r;
    in_valid = v;
    In1      = a;
    In2      = b;
    ctrl     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] exp_out,
                         input logic exp_vld, input logic exp_ovf);
    chk({tag, ".out"}, 16'(Out), exp_out);
    chk({tag, ".vld"}, 16'(out_valid), 16'(exp_vld));
    chk({tag, ".ovf"}, 16'(ovf), 16'(exp_ovf));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    In1      = '0;
    In2      = '0;
    ctrl     = 2'b00;
    #2;

    // Reset held two cycles with a valid operation presented
    step(1'b1, 1'b1, 16'sd7, 16'sd3, 2'b01);
    chk_all("rst0", 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'sd7, 16'sd3, 2'b01);
    chk_all("rst1", 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'sd7, 16'sd3, 2'b01);
    chk_all("first", 16'd10, 1'b1, 1'b0);

    // Basic ops on -5, 9
    step(1'b0, 1'b1, -16'sd5, 16'sd9, 2'b00);
    chk_all("sub", 16'hFFF2, 1'b1, 1'b0);
    step(1'b0, 1'b1, -16'sd5, 16'sd9, 2'b01);
    chk_all("add", 16'h0004, 1'b1, 1'b0);
    step(1'b0, 1'b1, -16'sd5, 16'sd9, 2'b10);
    chk_all("max10", 16'h0009, 1'b1, 1'b0);
    step(1'b0, 1'b1, -16'sd5, 16'sd9, 2'b11);
    chk_all("max11", 16'h0009, 1'b1, 1'b0);

    // Add overflow both directions
    step(1'b0, 1'b1, 16'sd32767, 16'sd1, 2'b01);
    chk_all("add_pos_ovf", 16'h8000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'sh8000, -16'sd1, 2'b01);
    chk_all("add_neg_ovf", 16'h7FFF, 1'b1, 1'b1);

    // Sub overflow both directions
    step(1'b0, 1'b1, 16'sh8000, 16'sd1, 2'b00);
    chk_all("sub_neg_ovf", 16'h7FFF, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'sd0, 16'sh8000, 2'b00);
    chk_all("sub_pos_ovf", 16'h8000, 1'b1, 1'b1);

    // Sub with differing signs but no overflow
    step(1'b0, 1'b1, 16'sd100, -16'sd200, 2'b00);
    chk_all("sub_nov", 16'd300, 1'b1, 1'b0);

    // Max corners
    step(1'b0, 1'b1, -16'sd1, 16'sh8000, 2'b10);
    chk_all("max_neg", 16'hFFFF, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'sd100, 16'sd100, 2'b11);
    chk_all("max_eq", 16'd100, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'sh8000, 16'sd32767, 2'b10);
    chk_all("max_ext", 16'h7FFF, 1'b1, 1'b0);

    // Valid gating: result holds when in_valid drops
    step(1'b0, 1'b1, 16'sd2, 16'sd3, 2'b01);
    chk_all("gate_in", 16'd5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'sd50, 16'sd3, 2'b01);
    chk_all("gate_hold", 16'd5, 1'b0, 1'b0);

    // Overflow flag also holds across an idle cycle
    step(1'b0, 1'b1, 16'sd32767, 16'sd1, 2'b01);
    chk_all("ovf_set", 16'h8000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'sd1, 16'sd1, 2'b00);
    chk_all("ovf_hold", 16'h8000, 1'b0, 1'b1);

    // Reset presented together with a valid input wins
    step(1'b1, 1'b1, 16'sd2, 16'sd3, 2'b01);
    chk_all("rst_prio", 16'h0000, 1'b0, 1'b0);

    // Reset in the cycle after a valid input clears it
    step(1'b0, 1'b1, 16'sd32767, 16'sd1, 2'b01);
    chk_all("pre_rst", 16'h8000, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'sd1, 16'sd1, 2'b01);
    chk_all("mid_rst", 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'sd1, 16'sd1, 2'b01);
    chk_all("post_rst", 16'd2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/au2.md
Name: au2

Overview:
- 2-input signed arithmetic unit for the SRA datapath.
- Performs subtract, add or signed maximum on two two's-complement operands, selected by a 2-bit control.
- The result is registered: 1 clock of latency, with a valid strobe and an overflow flag.
- Feeds downstream SRA accumulation/compare logic.

Parameters:
- msb, 15, index of the operand/result MSB; data width W = msb+1 (default 16 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- In1  in  W  operand A, signed two's complement.
- In2  in  W  operand B, signed two's complement.
- ctrl  in  2  operation select: 00 sub(A,B), 01 add(A,B), 10 max(A,B), 11 max(A,B).
- in_valid  in  1  operands and ctrl are valid this cycle.
- Out  out  W  registered result, signed.
- out_valid  out  1  Out/ovf hold a new result this cycle.
- ovf  out  1  signed overflow of the registered sub/add result.

Behaviour:
- Reset: when rst is 1 at a rising clk edge, Out=0, out_valid=0 and ovf=0 on the next cycle. Reset has priority over in_valid.
- Latency: operands sampled at edge N with in_valid=1 produce Out/ovf/out_valid=1 after edge N. This is single-cycle, fully pipelined, and accepts one operation per clock.
- No backpressure: there is no ready signal, and every in_valid is accepted.
- in_valid=0 at an edge: out_valid=0; Out and ovf hold their previous values.
- ctrl=00 (sub): Out = In1 - In2, computed on W+1 bits and truncated to W bits (wraps modulo 2^W). ovf=1 when the operand signs differ and the result sign differs from In1.
- ctrl=01 (add): Out = In1 + In2, wraps modulo 2^W. ovf=1 when the operand signs are equal and the result sign differs from them.
- ctrl=10 or 11 (max): Out = In1 if In1 >= In2 (signed compare), else In2. Equal operands yield In1. ovf=0 always.
- No saturation: wrapped results are output as-is; ovf only flags them.
- Reset mid-stream: a result in flight is discarded. The first valid input after reset is released produces a result one cycle later.
- All inputs are assumed stable around the rising edge. No combinational path from inputs to outputs.

Decomposition:
- Shared package au_pkg:
  - localparams AU_SUB=2'b00, AU_ADD=2'b01, AU_MAX=2'b10, AU_MAX2=2'b11.
  - Default data width 16.
- One sub-module is natural: au2_core, purely combinational. It takes A, B and ctrl and produces the result and overflow, which lets the same core be reused in the unregistered AU variants.
- au2 = au2_core + output register stage + valid register.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and In1=7, In2=3 -> Out=0, out_valid=0, ovf=0 throughout; first valid after release yields its result 1 cycle later.
- Basic ops on In1=-5, In2=9, stepping ctrl 00,01,10,11 on consecutive cycles with in_valid=1:
  - ctrl 00 -> Out=-14 (0xFFF2)
  - ctrl 01 -> Out=4
  - ctrl 10 -> Out=9
  - ctrl 11 -> Out=9
  - each result appears one cycle after its input, out_valid=1 every cycle, ovf=0.
- Add overflow: In1=32767, In2=1, ctrl=01 -> Out=-32768 (0x8000), ovf=1. Then In1=-32768, In2=-1, ctrl=01 -> Out=32767, ovf=1.
- Sub overflow: In1=-32768, In2=1, ctrl=00 -> Out=32767, ovf=1. Then In1=0, In2=-32768, ctrl=00 -> Out=-32768, ovf=1.
- Max edge cases:
  - In1=-1, In2=-32768, ctrl=10 -> Out=-1, ovf=0.
  - In1=100, In2=100, ctrl=11 -> Out=100.
  - In1=-32768, In2=32767, ctrl=10 -> Out=32767.
- Valid gating: after In1=2, In2=3, ctrl=01 (Out=5), drop in_valid and change In1=50 -> out_valid=0 and Out stays 5. Also assert rst in the cycle after a valid input -> that result is not presented (out_valid=0, Out=0).
